spmv_vec_fetch: RTL

//  Dense-vector gather stage for the SpMV kernel. It takes a stream of CSR nonzeros
//  {column index, matrix value, row-last flag}. For each one it issues a single-beat
//  32-bit AXI read of x[col] at vec_base + 4*col, then emits {matrix value, x value,
//  row-last} to the multiply-accumulate stage. It sits directly upstream of the narrow

---
 rtl/spmv_vec_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/spmv_vec_fetch.sv
// Dense-vector gather stage for SpMV: one single-beat AXI read of x[col] per CSR
// nonzero, emitting {matrix value, x value, row-last} downstream.
module spmv_vec_fetch #(
  parameter int ADDR_WIDTH     = 48,
  parameter int ID_WIDTH       = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int IDX_WIDTH      = 32,
  parameter int VAL_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] vec_base,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_WIDTH-1:0]  in_col,
  input  logic [VAL_WIDTH-1:0]  in_val,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VAL_WIDTH-1:0]  out_mat,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic                  out_last,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [31:0]           fetch_cnt,
  output logic                  timeout_err,
  output logic                  resp_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, AR, WAIT_R, OUT} state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [ADDR_WIDTH-1:0] col_off;

  // Byte offset of x[col]; any carry past ADDR_WIDTH is dropped so addresses wrap.
  assign col_off = ADDR_WIDTH'({in_col, 2'b00});

  assign in_ready      = (state == IDLE);
  assign m_axi_rready  = (state == WAIT_R);
  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;

  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      timer         <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      out_valid     <= 1'b0;
      out_mat       <= '0;
      out_x         <= '0;
      out_last      <= 1'b0;
      fetch_cnt     <= '0;
      timeout_err   <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_mat       <= in_val;
            out_last      <= in_last;
            m_axi_araddr  <= vec_base + col_off;
            m_axi_arvalid <= 1'b1;
            state         <= AR;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            timer         <= '0;
            state         <= WAIT_R;
          end
        end
        WAIT_R: begin
          // A response arriving on the timeout cycle still completes the fetch.
          if (m_axi_rvalid) begin
            out_x     <= m_axi_rdata;
            out_valid <= 1'b1;
            if (m_axi_rresp != 2'b00) resp_err <= 1'b1;
            state     <= OUT;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err   <= 1'b1;
            m_axi_arvalid <= 1'b1;
            state         <= AR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
